codificador_f_i: RTL and testbench

Input-side counterpart of the frequency/current display decoder. Accepts a 4-digit BCD value entered digit by digit (kHz for frequency, hundredths of the current unit for current). It converts the value to binary and searches the fixed setpoint tables to produce the 3-bit frequency index or 5-bit current index that drive the PWM counters. It sits between the keypad/button debouncer and the frequency/current counter load inputs.

---
 rtl/pwm_tablas_pkg.sv | 29 ++
 rtl/bcd_a_binario.sv | 49 ++++
 rtl/codificador_f_i.sv | 151 +++++++++++++++
 tb/tb_codificador_f_i.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_tablas_pkg.sv
// rtl/pwm_tablas_pkg.sv - PWM setpoint tables, index widths and FSM states for codificador_f_i
package pwm_tablas_pkg;

  localparam int FREC_W = 3;
  localparam int CORR_W = 5;
  localparam int BIN_W  = 14;

  localparam logic [BIN_W-1:0] CORR_MAX = 14'd999;

  localparam logic [BIN_W-1:0] TABLA_FREC [0:7] = '{
    14'd25, 14'd50, 14'd75, 14'd100, 14'd125, 14'd150, 14'd175, 14'd200
  };

  // Current setpoints in hundredths, matching the display decoder's table
  localparam logic [BIN_W-1:0] TABLA_CORR [0:31] = '{
    14'd0,   14'd31,  14'd62,  14'd94,  14'd125, 14'd156, 14'd187, 14'd219,
    14'd250, 14'd281, 14'd312, 14'd344, 14'd375, 14'd406, 14'd437, 14'd469,
    14'd500, 14'd531, 14'd562, 14'd594, 14'd625, 14'd656, 14'd687, 14'd719,
    14'd750, 14'd781, 14'd812, 14'd844, 14'd875, 14'd906, 14'd937, 14'd969
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } estado_t;

endpackage

// File: rtl/bcd_a_binario.sv
// rtl/bcd_a_binario.sv - 4-digit BCD to binary Horner converter, fixed 4-cycle latency
module bcd_a_binario
  import pwm_tablas_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             abortar,
  input  logic             start,
  input  logic [15:0]      digitos,
  output logic             done,
  output logic [BIN_W-1:0] resultado
);

  logic [11:0] resto;
  logic [1:0]  paso;
  logic        activo;

  // The start edge already folds in the most significant digit, so the
  // remaining three steps finish with done high in the fourth cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      resultado <= '0;
      resto     <= '0;
      paso      <= '0;
      activo    <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      resultado <= {10'd0, digitos[15:12]};
      resto     <= digitos[11:0];
      paso      <= '0;
      activo    <= 1'b1;
      done      <= 1'b0;
    end else if (abortar) begin
      activo <= 1'b0;
      done   <= 1'b0;
    end else if (activo) begin
      resultado <= resultado * 14'd10 + {10'd0, resto[11:8]};
      resto     <= {resto[7:0], 4'd0};
      paso      <= paso + 2'd1;
      if (paso == 2'd2) begin
        activo <= 1'b0;
        done   <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/codificador_f_i.sv
// rtl/codificador_f_i.sv - BCD keypad entry to PWM frequency/current index; CORRIENTE_REDONDEO_EN selects round-to-nearest current search
module codificador_f_i
  import pwm_tablas_pkg::*;
#(
  parameter int N_DIGITOS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             digito_in,
  input  logic                   digito_valido,
  input  logic                   borrar,
  input  logic                   enter,
  input  logic                   selector_F_I,
  output logic [FREC_W-1:0]      Frecuencia,
  output logic [CORR_W-1:0]      Corriente,
  output logic [4*N_DIGITOS-1:0] dato_Hx,
  output logic                   ocupado,
  output logic                   listo,
  output logic                   error
);

  estado_t estado, estado_sig;

  logic [CORR_W-1:0]      i, i_d, i_sig1;
  logic                   sel, sel_d;
  logic [BIN_W-1:0]       bin;
  logic                   conv_done, inicio, fuera_rango;
  logic                   digito_ok, frec_match, corr_corte, parada, exito;
  logic [4*N_DIGITOS-1:0] dato_desp, digitos_conv, dato_d;
  logic [FREC_W-1:0]      frec_d;
  logic [CORR_W-1:0]      corr_d;
  logic                   listo_d, error_d;

  assign digito_ok    = digito_valido && (digito_in <= 4'd9);
  assign dato_desp    = {dato_Hx[4*N_DIGITOS-5:0], digito_in};
  // A digit arriving with enter is converted together with the earlier ones
  assign digitos_conv = digito_ok ? dato_desp : dato_Hx;
  assign inicio       = (estado == IDLE) && enter && !borrar;

  bcd_a_binario u_bcd (
    .clk       (clk),
    .reset     (reset),
    .abortar   (borrar),
    .start     (inicio),
    .digitos   (digitos_conv),
    .done      (conv_done),
    .resultado (bin)
  );

  assign fuera_rango = sel && (bin > CORR_MAX);
  assign i_sig1      = i + 1'b1;
  assign frec_match  = (bin == TABLA_FREC[i[FREC_W-1:0]]);

`ifdef CORRIENTE_REDONDEO_EN
  logic [BIN_W:0] suma_vecinos;
  assign suma_vecinos = {1'b0, TABLA_CORR[i]} + {1'b0, TABLA_CORR[i_sig1]};
  assign corr_corte   = (bin < suma_vecinos[BIN_W:1]);
`else
  assign corr_corte   = (TABLA_CORR[i_sig1] > bin);
`endif

  assign parada = sel ? ((i == 5'd31) || corr_corte) : (frec_match || (i == 5'd7));
  assign exito  = sel | frec_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= IDLE;
      i          <= '0;
      sel        <= 1'b0;
      dato_Hx    <= '0;
      Frecuencia <= '0;
      Corriente  <= '0;
      listo      <= 1'b0;
      error      <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      estado     <= estado_sig;
      i          <= i_d;
      sel        <= sel_d;
      dato_Hx    <= dato_d;
      Frecuencia <= frec_d;
      Corriente  <= corr_d;
      listo      <= listo_d;
      error      <= error_d;
      ocupado    <= (estado_sig != IDLE);
    end
  end

  always_comb begin
    estado_sig = estado;
    if (borrar) begin
      estado_sig = IDLE;
    end else begin
      case (estado)
        IDLE:    if (enter) estado_sig = CONV;
        CONV:    if (conv_done) estado_sig = fuera_rango ? DONE : SEARCH;
        SEARCH:  if (parada) estado_sig = DONE;
        default: estado_sig = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; they change on the edge entering DONE
  always_comb begin
    dato_d  = dato_Hx;
    i_d     = i;
    sel_d   = sel;
    frec_d  = Frecuencia;
    corr_d  = Corriente;
    listo_d = 1'b0;
    error_d = 1'b0;
    if (borrar) begin
      dato_d = '0;
    end else begin
      case (estado)
        IDLE: begin
          if (digito_valido) begin
            if (digito_ok) dato_d = dato_desp;
            else           error_d = 1'b1;
          end
          if (enter) begin
            sel_d = selector_F_I;
            i_d   = '0;
          end
        end
        CONV: begin
          if (conv_done && fuera_rango) begin
            error_d = 1'b1;
            dato_d  = '0;
          end
        end
        SEARCH: begin
          if (parada) begin
            dato_d = '0;
            if (exito) begin
              listo_d = 1'b1;
              if (sel) corr_d = i;
              else     frec_d = i[FREC_W-1:0];
            end else begin
              error_d = 1'b1;
            end
          end else begin
            i_d = i_sig1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_f_i.sv
// tb/tb_codificador_f_i.sv - randomized self-checking bench for codificador_f_i against a table-search model
module tb_codificador_f_i;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digito_in = 4'd0;
  logic       digito_valido = 1'b0;
  logic       borrar = 1'b0;
  logic       enter = 1'b0;
  logic       selector_F_I = 1'b0;
  logic [2:0] Frecuencia;
  logic [4:0] Corriente;
  logic [15:0] dato_Hx;
  logic       ocupado, listo, error;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frec = 0;
  int exp_corr = 0;

  always #5 clk = ~clk;

  codificador_f_i dut (
    .clk           (clk),
    .reset         (reset),
    .digito_in     (digito_in),
    .digito_valido (digito_valido),
    .borrar        (borrar),
    .enter         (enter),
    .selector_F_I  (selector_F_I),
    .Frecuencia    (Frecuencia),
    .Corriente     (Corriente),
    .dato_Hx       (dato_Hx),
    .ocupado       (ocupado),
    .listo         (listo),
    .error         (error)
  );

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Current setpoint k in hundredths: 1000*k/32 rounded, halves going down
  function automatic int tc(input int k);
    return (k * 1000 + 15) / 32;
  endfunction

  function automatic void modelo(input bit sel, input int v,
                                 output bit err, output int idx, output int cyc);
    err = 1'b1; idx = 0; cyc = 13;
    if (!sel) begin
      for (int k = 0; k < 8; k++)
        if (v == 25 * (k + 1)) begin err = 1'b0; idx = k; cyc = 6 + k; end
    end else if (v > 999) begin
      cyc = 5;
    end else begin
      err = 1'b0;
`ifdef CORRIENTE_REDONDEO_EN
      idx = 31;
      for (int k = 30; k >= 0; k--)
        if (v < (tc(k) + tc(k + 1)) / 2) idx = k;
`else
      for (int k = 0; k < 32; k++)
        if (tc(k) <= v) idx = k;
`endif
      cyc = 6 + idx;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic meter_digito(input int d);
    digito_in = d[3:0];
    digito_valido = 1'b1;
    tick();
    digito_valido = 1'b0;
  endtask

  task automatic run(input bit sel, input int v, input bit combo, input bit ruido);
    int d[4];
    int bcd;
    int cyc, exp_cyc, idx;
    bit err;
    d[0] = (v / 1000) % 10; d[1] = (v / 100) % 10; d[2] = (v / 10) % 10; d[3] = v % 10;
    bcd = (d[0] << 12) | (d[1] << 8) | (d[2] << 4) | d[3];
    modelo(sel, v, err, idx, exp_cyc);
    for (int k = 0; k < 3; k++) meter_digito(d[k]);
    if (!combo) begin
      meter_digito(d[3]);
      check("dato_eco", dato_Hx, bcd);
    end else begin
      digito_in = d[3][3:0];
      digito_valido = 1'b1;
    end
    selector_F_I = sel;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    digito_valido = 1'b0;
    cyc = 1;
    check("ocupado_conv", ocupado, 1);
    while (!(listo || error) && cyc < 45) begin
      digito_valido = ruido && (cyc == 2);
      enter = ruido && (cyc == 2);
      digito_in = 4'd3;
      tick();
      cyc++;
    end
    digito_valido = 1'b0;
    enter = 1'b0;
    check("ciclo_fin", cyc, exp_cyc);
    check("listo", listo, !err);
    check("error", error, err);
    if (!err) begin
      if (sel) exp_corr = idx; else exp_frec = idx;
    end
    check("Frecuencia", Frecuencia, exp_frec);
    check("Corriente", Corriente, exp_corr);
    tick();
    check("ocupado_fin", ocupado, 0);
    check("dato_borrado", dato_Hx, 0);
  endtask

  initial begin
    int v, r;
    bit s;
    bit visto;
    tick(); tick();
    reset = 1'b0;
    check("rst_frec", Frecuencia, 0);
    check("rst_corr", Corriente, 0);
    check("rst_dato", dato_Hx, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_listo", listo, 0);
    check("rst_error", error, 0);

    run(1'b0, 125, 1'b0, 1'b0);
    run(1'b0, 130, 1'b0, 1'b0);
    run(1'b1, 500, 1'b0, 1'b0);
    run(1'b1, 499, 1'b0, 1'b0);
    run(1'b1, 0, 1'b0, 1'b0);
    run(1'b1, 985, 1'b0, 1'b0);
    run(1'b1, 1000, 1'b0, 1'b0);
    run(1'b0, 50, 1'b1, 1'b0);

    meter_digito(1); meter_digito(2);
    meter_digito(10);
    check("dig_inval_error", error, 1);
    check("dig_inval_dato", dato_Hx, 16'h0012);
    tick();
    check("dig_inval_pulso", error, 0);
    borrar = 1'b1; tick(); borrar = 1'b0;
    check("borrar_idle_dato", dato_Hx, 0);

    // Abort with borrar while the search is on index 2 (cycle 7)
    meter_digito(0); meter_digito(2); meter_digito(0); meter_digito(0);
    selector_F_I = 1'b0; enter = 1'b1; tick(); enter = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    borrar = 1'b1; tick(); borrar = 1'b0;
    check("borrar_ocupado", ocupado, 0);
    check("borrar_listo", listo, 0);
    check("borrar_error", error, 0);
    check("borrar_dato", dato_Hx, 0);
    visto = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (listo || error) visto = 1'b1;
      tick();
    end
    check("borrar_silencio", visto, 0);
    check("borrar_frec", Frecuencia, exp_frec);

    // Reset in the middle of a current search
    run(1'b1, 750, 1'b0, 1'b0);
    meter_digito(0); meter_digito(9); meter_digito(8); meter_digito(5);
    selector_F_I = 1'b1; enter = 1'b1; tick(); enter = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    exp_frec = 0; exp_corr = 0;
    check("rst_med_frec", Frecuencia, 0);
    check("rst_med_corr", Corriente, 0);
    check("rst_med_dato", dato_Hx, 0);
    check("rst_med_ocupado", ocupado, 0);
    check("rst_med_listo", listo, 0);
    check("rst_med_error", error, 0);
    run(1'b0, 200, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      s = $urandom_range(0, 1);
      r = $urandom_range(0, 3);
      if (!s) v = (r < 2) ? 25 * $urandom_range(1, 8) : (r == 2 ? $urandom_range(0, 250) : $urandom_range(0, 9999));
      else    v = (r < 3) ? $urandom_range(0, 999) : $urandom_range(0, 9999);
      run(s, v, $urandom_range(0, 3) == 0, $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
